// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  typedef logic [7:0] keycode_t;

  localparam keycode_t KEY_NONE = 8'h00;

  // Isolates the lowest set bit, so simultaneous columns resolve to the lowest index.
  function automatic logic [NUM_COLS-1:0] lowest_onehot(input logic [NUM_COLS-1:0] v);
    lowest_onehot = v & (-v);
  endfunction

endpackage

// File: rtl/keypad_stable_cnt.sv
// Saturating stability counter with synchronous clear; done marks DEB_CYC-1.
module keypad_stable_cnt
  import keypad_pkg::*;
#(
  parameter int unsigned DEB_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CW = $clog2(DEB_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic [CW-1:0] count_r;

  // Counts enabled cycles and parks at LAST until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign done = (count_r == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, debounce FSM and one-entry event buffer.
// Define KEYPAD_REPEAT_EN to re-emit a held key every REPEAT_CYC cycles.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL_CYC  = 16,
  parameter int unsigned DEB_CYC    = 1024,
  parameter int unsigned REPEAT_CYC = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_COLS-1:0] col,
  output logic [NUM_ROWS-1:0] row,
  output logic [7:0]          key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);

  localparam int unsigned DW = $clog2(DWELL_CYC);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);

  if ((DWELL_CYC < 2) || (DEB_CYC < 2) || (REPEAT_CYC < 2)) begin : g_param_check
    $error("keypad_scan_ctrl: cycle parameters must be >= 2");
  end

  kp_state_e           state_r;
  logic [NUM_ROWS-1:0] row_r;
  logic [DW-1:0]       dwell_r;
  logic [NUM_COLS-1:0] col_sel_r;
  logic                key_held_r;
  keycode_t            key_code_r;
  logic                key_valid_r;
  logic                overrun_r;

  logic                key_bit_s;
  logic                deb_done_s;
  logic                cnt_clr_s;
  logic                cnt_en_s;
  logic                press_ev_s;
  logic                rep_ev_s;
  logic                ev_s;
  logic [NUM_ROWS-1:0] next_row_s;

  assign key_bit_s  = |(col & col_sel_r);
  assign next_row_s = {row_r[NUM_ROWS-2:0], row_r[NUM_ROWS-1]};
  assign press_ev_s = (state_r == DEBOUNCE) && key_bit_s && deb_done_s;
  assign ev_s       = press_ev_s || rep_ev_s;

  // One counter serves both the press and the release stability windows
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_r)
      SCAN:     cnt_clr_s = 1'b1;
      DEBOUNCE: cnt_en_s  = key_bit_s;
      PRESSED:  cnt_clr_s = 1'b1;
      RELEASE:  cnt_en_s  = !key_bit_s;
      default:  cnt_clr_s = 1'b1;
    endcase
  end

  keypad_stable_cnt #(.DEB_CYC(DEB_CYC)) u_stable_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr_s),
    .en   (cnt_en_s),
    .done (deb_done_s)
  );

  // Scan/debounce FSM; the row and dwell counter stay frozen outside SCAN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= SCAN;
      row_r      <= 4'b0001;
      dwell_r    <= {DW{1'b0}};
      col_sel_r  <= 4'b0000;
      key_held_r <= 1'b0;
    end else begin
      case (state_r)
        SCAN: begin
          if (dwell_r == DWELL_LAST) begin
            if (col != 4'b0000) begin
              col_sel_r <= lowest_onehot(col);
              state_r   <= DEBOUNCE;
            end else begin
              row_r   <= next_row_s;
              dwell_r <= {DW{1'b0}};
            end
          end else begin
            dwell_r <= dwell_r + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!key_bit_s) begin
            state_r <= SCAN;
            row_r   <= next_row_s;
            dwell_r <= {DW{1'b0}};
          end else if (deb_done_s) begin
            state_r    <= PRESSED;
            key_held_r <= 1'b1;
          end
        end
        PRESSED: begin
          if (!key_bit_s) begin
            state_r <= RELEASE;
          end
        end
        RELEASE: begin
          if (key_bit_s) begin
            state_r <= PRESSED;
          end else if (deb_done_s) begin
            state_r    <= SCAN;
            key_held_r <= 1'b0;
            row_r      <= next_row_s;
            dwell_r    <= {DW{1'b0}};
          end
        end
        default: begin
          state_r <= SCAN;
        end
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_cnt_r;

  assign rep_ev_s = (state_r == PRESSED) && key_bit_s && (rep_cnt_r == REP_LAST);

  // Repeat timer restarts whenever PRESSED is (re)entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_r <= {RW{1'b0}};
    end else if ((state_r != PRESSED) || (rep_cnt_r == REP_LAST)) begin
      rep_cnt_r <= {RW{1'b0}};
    end else begin
      rep_cnt_r <= rep_cnt_r + 1'b1;
    end
  end
`else
  assign rep_ev_s = 1'b0;
`endif

  // Single-entry output buffer; a full, unaccepted slot drops the new event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_r  <= KEY_NONE;
      key_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (ev_s) begin
        if (!key_valid_r || key_ready) begin
          key_code_r  <= {row_r, col_sel_r};
          key_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (key_valid_r && key_ready) begin
        key_valid_r <= 1'b0;
      end
    end
  end

  assign row       = row_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;
  assign overrun   = overrun_r;

endmodule
